ram_arbiter: RTL and testbench



---
 rtl/ram_arbiter.sv | 105 ++++++++++
 tb/tb_ram_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one synchronous RAM port (1-cycle read latency) between
// two requesters. It uses a req/ack handshake and round-robin arbitration on ties.
// A sampled request produces its ack pulse two cycles after the grant edge.
module ram_arbiter #(
    parameter int unsigned g_RAM_WIDTH = 9,
    parameter int unsigned g_RAM_ADDR  = 11
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_p0_req,
    input  logic                   i_p0_we,
    input  logic [g_RAM_ADDR-1:0]  i_p0_addr,
    input  logic [g_RAM_WIDTH-1:0] i_p0_data,
    output logic                   o_p0_ack,
    output logic [g_RAM_WIDTH-1:0] o_p0_data,
    input  logic                   i_p1_req,
    input  logic                   i_p1_we,
    input  logic [g_RAM_ADDR-1:0]  i_p1_addr,
    input  logic [g_RAM_WIDTH-1:0] i_p1_data,
    output logic                   o_p1_ack,
    output logic [g_RAM_WIDTH-1:0] o_p1_data,
    output logic                   o_ram_en,
    output logic                   o_ram_we,
    output logic [g_RAM_ADDR-1:0]  o_ram_addr,
    output logic [g_RAM_WIDTH-1:0] o_ram_data,
    input  logic [g_RAM_WIDTH-1:0] i_ram_data,
    output logic                   o_busy,
    output logic                   o_grant
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t r_state;
    logic   r_last;
    logic   win_c;

    // Winner of the IDLE sample: the lone requester, or the port not served last on a tie
    always_comb begin
        win_c = 1'b0;
        if (i_p0_req && i_p1_req) begin
            win_c = ~r_last;
        end else begin
            win_c = i_p1_req;
        end
    end

    // Arbitration FSM with all outputs registered
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_last     <= 1'b1;
            o_ram_en   <= 1'b0;
            o_ram_we   <= 1'b0;
            o_ram_addr <= '0;
            o_ram_data <= '0;
            o_p0_ack   <= 1'b0;
            o_p1_ack   <= 1'b0;
            o_p0_data  <= '0;
            o_p1_data  <= '0;
            o_busy     <= 1'b0;
            o_grant    <= 1'b0;
        end else begin
            o_p0_ack <= 1'b0;
            o_p1_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_p0_req || i_p1_req) begin
                        o_ram_en   <= 1'b1;
                        o_ram_we   <= win_c ? i_p1_we   : i_p0_we;
                        o_ram_addr <= win_c ? i_p1_addr : i_p0_addr;
                        o_ram_data <= win_c ? i_p1_data : i_p0_data;
                        o_grant    <= win_c;
                        r_last     <= win_c;
                        o_busy     <= 1'b1;
                        r_state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    o_ram_en <= 1'b0;
                    o_ram_we <= 1'b0;
                    r_state  <= DONE;
                end
                DONE: begin
                    if (o_grant) begin
                        o_p1_data <= i_ram_data;
                        o_p1_ack  <= 1'b1;
                    end else begin
                        o_p0_data <= i_ram_data;
                        o_p0_ack  <= 1'b1;
                    end
                    o_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus a randomized
// two-requester run checked against a transaction-level timeline model.
module tb_ram_arbiter;

    localparam int unsigned W = 9;
    localparam int unsigned A = 11;

    logic         clk;
    logic         i_rst_n;
    logic         i_p0_req, i_p0_we, i_p1_req, i_p1_we;
    logic [A-1:0] i_p0_addr, i_p1_addr;
    logic [W-1:0] i_p0_data, i_p1_data;
    logic         o_p0_ack, o_p1_ack;
    logic [W-1:0] o_p0_data, o_p1_data;
    logic         o_ram_en, o_ram_we;
    logic [A-1:0] o_ram_addr;
    logic [W-1:0] o_ram_data;
    logic [W-1:0] i_ram_data;
    logic         o_busy, o_grant;

    int checks = 0;
    int errors = 0;

    // RAM macro model with a preload path
    logic         pl_en;
    logic [A-1:0] pl_addr;
    logic [W-1:0] pl_data;
    logic [W-1:0] mem [0:2047];
    logic [W-1:0] ram_q;

    // Reference contents of the RAM as seen by completed/granted accesses
    logic [W-1:0] ref_mem [0:2047];

    // Random-phase requester and model state
    bit           pend [2];
    logic         rq_we [2];
    logic [A-1:0] rq_ad [2];
    logic [W-1:0] rq_dt [2];

    ram_arbiter #(.g_RAM_WIDTH(W), .g_RAM_ADDR(A)) dut (
        .i_clk     (clk),
        .i_rst_n   (i_rst_n),
        .i_p0_req  (i_p0_req),
        .i_p0_we   (i_p0_we),
        .i_p0_addr (i_p0_addr),
        .i_p0_data (i_p0_data),
        .o_p0_ack  (o_p0_ack),
        .o_p0_data (o_p0_data),
        .i_p1_req  (i_p1_req),
        .i_p1_we   (i_p1_we),
        .i_p1_addr (i_p1_addr),
        .i_p1_data (i_p1_data),
        .o_p1_ack  (o_p1_ack),
        .o_p1_data (o_p1_data),
        .o_ram_en  (o_ram_en),
        .o_ram_we  (o_ram_we),
        .o_ram_addr(o_ram_addr),
        .o_ram_data(o_ram_data),
        .i_ram_data(i_ram_data),
        .o_busy    (o_busy),
        .o_grant   (o_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM, read-first, 1-cycle read latency
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (o_ram_en) begin
            ram_q <= mem[o_ram_addr];
            if (o_ram_we) mem[o_ram_addr] <= o_ram_data;
        end
    end
    assign i_ram_data = ram_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [A-1:0] a, input logic [W-1:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        ref_mem[a] = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic set_port(input int p, input logic r, input logic we,
                            input logic [A-1:0] a, input logic [W-1:0] d);
        if (p == 0) begin
            i_p0_req = r; i_p0_we = we; i_p0_addr = a; i_p0_data = d;
        end else begin
            i_p1_req = r; i_p1_we = we; i_p1_addr = a; i_p1_data = d;
        end
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        i_rst_n = 1'b1;
    endtask

    // Single access by one port with full latency checks
    task automatic do_access(input int p, input logic we, input logic [A-1:0] a,
                             input logic [W-1:0] d);
        logic [W-1:0] exp_rd;
        exp_rd = ref_mem[a];
        set_port(p, 1'b1, we, a, d);
        @(negedge clk);
        chk("acc_en", o_ram_en, 1);
        chk("acc_we", o_ram_we, we);
        chk("acc_addr", o_ram_addr, a);
        if (we) chk("acc_wdata", o_ram_data, d);
        chk("acc_grant", o_grant, p);
        chk("acc_busy", o_busy, 1);
        @(negedge clk);
        chk("done_en", o_ram_en, 0);
        chk("done_we", o_ram_we, 0);
        chk("done_ack0", o_p0_ack, 0);
        chk("done_ack1", o_p1_ack, 0);
        chk("done_busy", o_busy, 1);
        @(negedge clk);
        chk("ack_own", (p == 0) ? o_p0_ack : o_p1_ack, 1);
        chk("ack_other", (p == 0) ? o_p1_ack : o_p0_ack, 0);
        if (!we) chk("ack_rdata", (p == 0) ? o_p0_data : o_p1_data, exp_rd);
        chk("ack_busy", o_busy, 0);
        if (we) ref_mem[a] = d;
        set_port(p, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("post_ack", (p == 0) ? o_p0_ack : o_p1_ack, 0);
        chk("post_en", o_ram_en, 0);
    endtask

    // Both ports reading continuously; port 0 is expected to win first
    task automatic tie_run(input int n, input logic [A-1:0] a0, input logic [A-1:0] a1);
        int q;
        set_port(0, 1'b1, 1'b0, a0, '0);
        set_port(1, 1'b1, 1'b0, a1, '0);
        for (int k = 0; k < 3 * n; k++) begin
            @(negedge clk);
            q = (k / 3) % 2;
            if (k % 3 == 0) begin
                chk("tie_en", o_ram_en, 1);
                chk("tie_grant", o_grant, q);
            end
            chk("tie_ack0", o_p0_ack, (k % 3 == 2) && (q == 0));
            chk("tie_ack1", o_p1_ack, (k % 3 == 2) && (q == 1));
            if (k % 3 == 2) begin
                chk("tie_rdata", (q == 0) ? o_p0_data : o_p1_data,
                    (q == 0) ? ref_mem[a0] : ref_mem[a1]);
            end
        end
        set_port(0, 1'b0, 1'b0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("tie_idle_en", o_ram_en, 0);
    endtask

    initial begin
        int   ack_due, ack_port, next_free;
        logic ack_rd, m_last, w;
        logic [W-1:0] ack_dat;

        i_rst_n = 1'b0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        set_port(0, 1'b0, 1'b0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);

        // Reset values (reset held low)
        chk("rst_en", o_ram_en, 0);
        chk("rst_we", o_ram_we, 0);
        chk("rst_addr", o_ram_addr, 0);
        chk("rst_wdata", o_ram_data, 0);
        chk("rst_ack0", o_p0_ack, 0);
        chk("rst_ack1", o_p1_ack, 0);
        chk("rst_d0", o_p0_data, 0);
        chk("rst_d1", o_p1_data, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_grant", o_grant, 0);

        preload(11'h005, 9'h1A5);
        preload(11'h7FF, 9'h011);
        preload(11'h100, 9'h0C3);
        preload(11'h101, 9'h13C);
        preload(11'h010, 9'h055);
        preload(11'h012, 9'h1E1);
        preload(11'h020, 9'h0AA);
        preload(11'h021, 9'h077);
        i_rst_n = 1'b1;
        @(negedge clk);

        // Single read, then p1 write and p0 read-back
        do_access(0, 1'b0, 11'h005, 9'h000);
        do_access(1, 1'b1, 11'h7FF, 9'h0F3);
        chk("hold_d0", o_p0_data, 9'h1A5);
        do_access(0, 1'b0, 11'h7FF, 9'h000);

        // Simultaneous requests after reset: alternating grants
        do_reset();
        tie_run(6, 11'h100, 11'h101);

        // Input changes mid-access are ignored
        set_port(0, 1'b1, 1'b0, 11'h010, '0);
        @(negedge clk);
        chk("mid_en", o_ram_en, 1);
        chk("mid_addr0", o_ram_addr, 11'h010);
        i_p0_addr = 11'h011;
        set_port(1, 1'b1, 1'b0, 11'h012, '0);
        @(negedge clk);
        chk("mid_addr1", o_ram_addr, 11'h010);
        chk("mid_nogrant", o_ram_en, 0);
        @(negedge clk);
        chk("mid_ack0", o_p0_ack, 1);
        chk("mid_ack1", o_p1_ack, 0);
        chk("mid_rdata", o_p0_data, ref_mem[11'h010]);
        chk("mid_addr2", o_ram_addr, 11'h010);
        chk("mid_en2", o_ram_en, 0);
        set_port(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("mid_p1_en", o_ram_en, 1);
        chk("mid_p1_addr", o_ram_addr, 11'h012);
        chk("mid_p1_grant", o_grant, 1);
        @(negedge clk);
        @(negedge clk);
        chk("mid_p1_ack", o_p1_ack, 1);
        chk("mid_p1_rdata", o_p1_data, ref_mem[11'h012]);
        set_port(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);

        // Reset during the ACCESS cycle of a write drops it
        set_port(0, 1'b1, 1'b1, 11'h020, 9'h155);
        @(negedge clk);
        chk("rmid_en_pre", o_ram_en, 1);
        chk("rmid_we_pre", o_ram_we, 1);
        #2 i_rst_n = 1'b0;
        #1;
        chk("rmid_en", o_ram_en, 0);
        chk("rmid_we", o_ram_we, 0);
        chk("rmid_ack0", o_p0_ack, 0);
        chk("rmid_ack1", o_p1_ack, 0);
        chk("rmid_busy", o_busy, 0);
        set_port(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        i_rst_n = 1'b1;
        tie_run(2, 11'h020, 11'h021);

        // Randomized two-requester run against the timeline model
        for (int a = 0; a < 16; a++) preload(A'(a), W'($urandom));
        pend[0] = 1'b0; pend[1] = 1'b0;
        m_last = 1'b1;
        ack_due = -1; ack_port = 0; ack_rd = 1'b0; ack_dat = '0;
        next_free = 1;
        for (int t = 0; t < 600; t++) begin
            chk("rnd_ack0", o_p0_ack, (ack_due == t) && (ack_port == 0));
            chk("rnd_ack1", o_p1_ack, (ack_due == t) && (ack_port == 1));
            chk("rnd_busy", o_busy, (ack_due - t == 1) || (ack_due - t == 2));
            if (ack_due == t) begin
                chk("rnd_grant", o_grant, ack_port);
                if (ack_rd) chk("rnd_rdata", (ack_port == 0) ? o_p0_data : o_p1_data, ack_dat);
                pend[ack_port] = 1'b0;
            end
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && ($urandom % 3 == 0)) begin
                    pend[p]  = 1'b1;
                    rq_we[p] = 1'($urandom);
                    rq_ad[p] = A'($urandom_range(15, 0));
                    rq_dt[p] = W'($urandom);
                end
                if (pend[p]) set_port(p, 1'b1, rq_we[p], rq_ad[p], rq_dt[p]);
                else         set_port(p, 1'b0, 1'($urandom), A'($urandom), W'($urandom));
            end
            if ((t + 1 >= next_free) && (pend[0] || pend[1])) begin
                w = (pend[0] && pend[1]) ? ~m_last : pend[1];
                m_last   = w;
                ack_port = int'(w);
                ack_rd   = ~rq_we[ack_port];
                ack_dat  = ref_mem[rq_ad[ack_port]];
                if (rq_we[ack_port]) ref_mem[rq_ad[ack_port]] = rq_dt[ack_port];
                ack_due   = t + 3;
                next_free = t + 4;
            end
            @(negedge clk);
        end
        set_port(0, 1'b0, 1'b0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0);
        repeat (4) @(negedge clk);
        chk("end_busy", o_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
